// File: rtl/fp_divider_pkg.sv
// Shared types and constant builders for the sequential IEEE-754 divider.
package fp_div_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_DIVIDE, ST_ROUND} state_e;

  typedef enum logic [2:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_QNAN, CLS_SNAN} cls_e;

  // Bit positions inside flags = {invalid, div_by_zero, overflow, underflow, inexact}
  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  function automatic int f_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Constants come back 64 bits wide; callers size-cast to their format width.
  function automatic logic [63:0] f_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [63:0] f_inf(input logic s, input int exp_w, input int man_w);
    return ({63'd0, s} << (exp_w + man_w)) | (((64'd1 << exp_w) - 64'd1) << man_w);
  endfunction

endpackage

// File: rtl/fp_divider_if.sv
// Start/busy/valid handshake and operand/result bus of the divider.
interface fp_divider_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         valid;
  logic [W-1:0] result;
  logic [4:0]   flags;

  modport master (output start, dividend, divisor, input busy, valid, result, flags);
  modport slave  (input start, dividend, divisor, output busy, valid, result, flags);
endinterface

// File: rtl/fp_divider_classify.sv
// Combinational operand classifier; subnormals are reported as zero (flush).
module fp_classify
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W-1:0] i_mag,
  output cls_e                   o_cls
);
  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_frac;

  assign w_exp  = i_mag[EXP_W+MAN_W-1:MAN_W];
  assign w_frac = i_mag[MAN_W-1:0];

  always_comb begin
    o_cls = CLS_NORM;
    if (w_exp == '0)           o_cls = CLS_ZERO;
    else if (&w_exp) begin
      if (w_frac == '0)        o_cls = CLS_INF;
      else if (w_frac[MAN_W-1]) o_cls = CLS_QNAN;
      else                     o_cls = CLS_SNAN;
    end
  end
endmodule

// File: rtl/fp_divider.sv
// Radix-2 restoring IEEE-754 divider: one quotient bit per cycle, then a single RNE round cycle.
module fp_divider
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic        clk,
  input  logic        rst,
  fp_divider_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int QW = MAN_W + 3;
  localparam int RW = MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(MAN_W + 4);

  localparam logic [W-1:0]          QNAN   = W'(f_qnan(EXP_W, MAN_W));
  localparam logic signed [EW-1:0]  BIAS   = EW'(f_bias(EXP_W));
  localparam logic signed [EW-1:0]  EMAX   = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0]  ZERO_E = '0;
  localparam logic signed [EW-1:0]  ONE_E  = EW'(1);
  localparam logic [CW-1:0]         LAST   = CW'(MAN_W + 2);

  state_e                r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [RW-1:0]         r_rem;
  logic [MAN_W:0]        r_dsr;
  logic [QW-1:0]         r_quo;
  logic signed [EW-1:0]  r_exp;
  logic                  r_sign, r_spec, r_valid;
  logic [W-1:0]          r_sres, r_result;
  logic [4:0]            r_sflg, r_flags;

  cls_e                  w_cls_a, w_cls_b;
  logic                  w_sign, w_is_spec;
  logic [W-1:0]          w_sres, w_res;
  logic [4:0]            w_sflg, w_flg;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.i_mag(bus.dividend[W-2:0]), .o_cls(w_cls_a));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.i_mag(bus.divisor[W-2:0]),  .o_cls(w_cls_b));

  assign w_sign = bus.dividend[W-1] ^ bus.divisor[W-1];

  // Fast-path result for any zero/inf/NaN operand, resolved at accept time.
  always_comb begin
    logic w_nan, w_snan, w_zz, w_ii;
    w_nan     = (w_cls_a inside {CLS_QNAN, CLS_SNAN}) || (w_cls_b inside {CLS_QNAN, CLS_SNAN});
    w_snan    = (w_cls_a == CLS_SNAN) || (w_cls_b == CLS_SNAN);
    w_zz      = (w_cls_a == CLS_ZERO) && (w_cls_b == CLS_ZERO);
    w_ii      = (w_cls_a == CLS_INF)  && (w_cls_b == CLS_INF);
    w_is_spec = (w_cls_a != CLS_NORM) || (w_cls_b != CLS_NORM);
    w_sres    = '0;
    w_sflg    = '0;
    if (w_nan || w_zz || w_ii) begin
      w_sres         = QNAN;
      w_sflg[FLG_NV] = w_snan | w_zz | w_ii;
    end else if (w_cls_a == CLS_NORM && w_cls_b == CLS_ZERO) begin
      w_sres         = W'(f_inf(w_sign, EXP_W, MAN_W));
      w_sflg[FLG_DZ] = 1'b1;
    end else if (w_cls_a == CLS_ZERO || w_cls_b == CLS_INF) begin
      w_sres = {w_sign, {(W-1){1'b0}}};
    end else if (w_cls_a == CLS_INF) begin
      w_sres = W'(f_inf(w_sign, EXP_W, MAN_W));
    end
  end

  // One restoring step
  logic [RW-1:0] w_dsr_ext, w_diff, w_rem_nx;
  logic          w_ge;
  assign w_dsr_ext = {1'b0, r_dsr};
  assign w_ge      = (r_rem >= w_dsr_ext);
  assign w_diff    = w_ge ? (r_rem - w_dsr_ext) : r_rem;
  assign w_rem_nx  = w_diff << 1;

  // Normalise to a leading 1 dropped off the top; w_qf holds fraction, G, R.
  logic [QW-2:0]        w_qf;
  logic signed [EW-1:0] w_e0, w_e1;
  logic [MAN_W:0]       w_mant;
  logic                 w_g, w_r, w_s, w_inc;
  assign w_qf   = r_quo[QW-1] ? r_quo[QW-2:0] : {r_quo[QW-3:0], 1'b0};
  assign w_e0   = r_quo[QW-1] ? r_exp : (r_exp - ONE_E);
  assign w_g    = w_qf[1];
  assign w_r    = w_qf[0];
  assign w_s    = (r_rem != '0);
  assign w_inc  = w_g & (w_r | w_s | w_qf[2]);
  assign w_mant = {1'b0, w_qf[QW-2:2]} + (MAN_W+1)'(w_inc);
  assign w_e1   = w_e0 + (w_mant[MAN_W] ? ONE_E : ZERO_E);

  always_comb begin
    w_res = '0;
    w_flg = '0;
    if (w_e1 >= EMAX) begin
      w_res         = W'(f_inf(r_sign, EXP_W, MAN_W));
      w_flg[FLG_OF] = 1'b1;
      w_flg[FLG_NX] = 1'b1;
    end else if (w_e1 <= ZERO_E) begin
      w_res         = {r_sign, {(W-1){1'b0}}};
      w_flg[FLG_UF] = 1'b1;
      w_flg[FLG_NX] = 1'b1;
    end else begin
      w_res         = {r_sign, w_e1[EXP_W-1:0], w_mant[MAN_W-1:0]};
      w_flg[FLG_NX] = w_g | w_r | w_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.start) w_next = w_is_spec ? ST_ROUND : ST_DIVIDE;
      ST_DIVIDE: if (r_cnt == LAST) w_next = ST_ROUND;
      ST_ROUND:  w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dsr    <= '0;
      r_quo    <= '0;
      r_exp    <= '0;
      r_sign   <= 1'b0;
      r_spec   <= 1'b0;
      r_sres   <= '0;
      r_sflg   <= '0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: if (bus.start) begin
          r_sign <= w_sign;
          r_spec <= w_is_spec;
          r_sres <= w_sres;
          r_sflg <= w_sflg;
          r_rem  <= {1'b0, 1'b1, bus.dividend[MAN_W-1:0]};
          r_dsr  <= {1'b1, bus.divisor[MAN_W-1:0]};
          r_quo  <= '0;
          r_cnt  <= '0;
          r_exp  <= $signed({2'b00, bus.dividend[W-2:MAN_W]})
                  - $signed({2'b00, bus.divisor[W-2:MAN_W]}) + BIAS;
        end
        ST_DIVIDE: begin
          r_rem <= w_rem_nx;
          r_quo <= {r_quo[QW-2:0], w_ge};
          r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
        ST_ROUND: begin
          r_valid  <= 1'b1;
          r_result <= r_spec ? r_sres : w_res;
          r_flags  <= r_spec ? r_sflg : w_flg;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.valid  = r_valid;
  assign bus.result = r_result;
  assign bus.flags  = r_flags;

endmodule

// File: tb/tb_fp_divider.sv
// Bench for fp_divider: directed table, handshake/reset sequences, random ops vs. arithmetic model.
module tb_fp_divider;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_divider_if #(.EXP_W(8), .MAN_W(23)) s_if ();
  fp_divider_if #(.EXP_W(5), .MAN_W(10)) h_if ();

  fp_divider #(.EXP_W(8), .MAN_W(23)) dut_s (.clk(clk), .rst(rst), .bus(s_if));
  fp_divider #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .rst(rst), .bus(h_if));

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          hp;
    logic [31:0] a, b, res;
    logic [4:0]  fl;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: exact integer quotient with MAN_W+3 bits, then spec rounding rules.
  function automatic void ref_div(input longint unsigned a, input longint unsigned b,
                                  input int ew, input int mw,
                                  output longint unsigned res, output logic [4:0] fl,
                                  output bit spec);
    longint unsigned emax, ea, eb, fa, fb, sgn, qn, inf, zr, ma, mb, num, q, m;
    longint e;
    bit za, zb, ia, ib, na, nb, sa, sb, st, g, r;
    int w;
    w    = 1 + ew + mw;
    emax = (64'd1 << ew) - 1;
    sgn  = ((a >> (w-1)) ^ (b >> (w-1))) & 1;
    ea = (a >> mw) & emax;  fa = a & ((64'd1 << mw) - 1);
    eb = (b >> mw) & emax;  fb = b & ((64'd1 << mw) - 1);
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == emax) && (fa == 0); ib = (eb == emax) && (fb == 0);
    na = (ea == emax) && (fa != 0); nb = (eb == emax) && (fb != 0);
    sa = na && (((fa >> (mw-1)) & 1) == 0);
    sb = nb && (((fb >> (mw-1)) & 1) == 0);
    qn  = (emax << mw) | (64'd1 << (mw-1));
    inf = (sgn << (w-1)) | (emax << mw);
    zr  = sgn << (w-1);
    fl = '0; res = 0;
    spec = za || zb || ia || ib || na || nb;
    if (na || nb || (za && zb) || (ia && ib)) begin
      res = qn; fl[4] = sa || sb || (za && zb) || (ia && ib);
    end else if (zb && !ia) begin
      res = inf; fl[3] = 1'b1;
    end else if (za || ib) res = zr;
    else if (ia) res = inf;
    else begin
      ma = (64'd1 << mw) | fa;
      mb = (64'd1 << mw) | fb;
      num = ma << (mw + 2);
      q = num / mb;
      st = (num % mb) != 0;
      e = longint'(ea) - longint'(eb) + ((64'sd1 <<< (ew-1)) - 1);
      if (q < (64'd1 << (mw + 2))) begin q = q << 1; e = e - 1; end
      g = q[1]; r = q[0];
      m = q >> 2;
      if (g && (r || st || m[0])) m = m + 1;
      if (m >= (64'd2 << mw)) begin m = m >> 1; e = e + 1; end
      if (e >= longint'(emax))  begin res = inf; fl = 5'b00101; end
      else if (e <= 0)          begin res = zr;  fl = 5'b00011; end
      else begin
        res = (sgn << (w-1)) | (longint'(e) << mw) | (m & ((64'd1 << mw) - 1));
        fl[0] = g | r | st;
      end
    end
  endfunction

  // Count edges until valid, sampled 1ns after each edge; lat=-1 on timeout.
  task automatic wait_valid(input bit hp, input int max, output int lat);
    bit v;
    lat = 0; v = 1'b0;
    while (!v && lat < max) begin
      @(posedge clk); #1;
      lat++;
      v = hp ? h_if.valid : s_if.valid;
    end
    if (!v) lat = -1;
  endtask

  task automatic run(input bit hp, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] res, output logic [4:0] fl, output int lat,
                     output logic b0, output logic bend);
    if (hp) begin h_if.start = 1'b1; h_if.dividend = a[15:0]; h_if.divisor = b[15:0]; end
    else    begin s_if.start = 1'b1; s_if.dividend = a;       s_if.divisor = b;       end
    @(posedge clk); #1;
    s_if.start = 1'b0; h_if.start = 1'b0;
    b0 = hp ? h_if.busy : s_if.busy;
    wait_valid(hp, 100, lat);
    res  = hp ? {16'h0, h_if.result} : s_if.result;
    fl   = hp ? h_if.flags : s_if.flags;
    bend = hp ? h_if.busy : s_if.busy;
  endtask

  vec_t vt[13];
  logic [31:0] res, ra, rb;
  logic [4:0]  fl, efl;
  logic        b0, bend;
  longint unsigned eres;
  bit          espec;
  int          lat, lat2, nval;

  initial begin
    s_if.start = 1'b0; s_if.dividend = '0; s_if.divisor = '0;
    h_if.start = 1'b0; h_if.dividend = '0; h_if.divisor = '0;

    vt[0]  = '{1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 27};
    vt[1]  = '{1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 27};
    vt[2]  = '{1'b0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 27};
    vt[3]  = '{1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1};
    vt[4]  = '{1'b0, 32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1};
    vt[5]  = '{1'b0, 32'hFF800000, 32'h3F800000, 32'hFF800000, 5'b00000, 1};
    vt[6]  = '{1'b0, 32'h3F800000, 32'h7F800000, 32'h00000000, 5'b00000, 1};
    vt[7]  = '{1'b0, 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101, 27};
    vt[8]  = '{1'b0, 32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 27};
    vt[9]  = '{1'b1, 32'h00004200, 32'h00003C00, 32'h00004200, 5'b00000, 14};
    vt[10] = '{1'b1, 32'h00003C00, 32'h00004200, 32'h00003555, 5'b00001, 14};
    vt[11] = '{1'b0, 32'h7FA00000, 32'h3F800000, 32'h7FC00000, 5'b10000, 1};
    vt[12] = '{1'b0, 32'hBF800000, 32'h00000000, 32'hFF800000, 5'b01000, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   s_if.busy,   0);
    chk("rst_valid",  s_if.valid,  0);
    chk("rst_result", s_if.result, 0);
    chk("rst_flags",  s_if.flags,  0);
    chk("rst_h_busy", h_if.busy,   0);
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      run(vt[i].hp, vt[i].a, vt[i].b, res, fl, lat, b0, bend);
      chk($sformatf("vec%0d_res", i), res, vt[i].res);
      chk($sformatf("vec%0d_flags", i), fl, vt[i].fl);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_busy0", i), b0, 1);
      chk($sformatf("vec%0d_busyend", i), bend, 0);
      @(posedge clk); #1;
    end

    // Start pulsed mid-operation with different operands must be ignored.
    s_if.start = 1'b1; s_if.dividend = 32'h40C00000; s_if.divisor = 32'h40000000;
    @(posedge clk); #1;
    s_if.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    s_if.start = 1'b1; s_if.dividend = 32'h3F800000; s_if.divisor = 32'h40400000;
    @(posedge clk); #1;
    s_if.start = 1'b0;
    wait_valid(1'b0, 60, lat);
    chk("midstart_lat", lat + 5, 27);
    chk("midstart_res", s_if.result, 32'h40400000);
    chk("midstart_flags", s_if.flags, 0);
    nval = 0;
    repeat (40) begin @(posedge clk); #1; if (s_if.valid) nval++; end
    chk("midstart_noqueue", nval, 0);

    // Back-to-back: second start issued in the valid cycle of the first.
    run(1'b0, 32'h40C00000, 32'h40000000, res, fl, lat, b0, bend);
    chk("b2b_first_res", res, 32'h40400000);
    chk("b2b_idle_on_valid", bend, 0);
    run(1'b0, 32'h3F800000, 32'h40400000, res, fl, lat2, b0, bend);
    chk("b2b_second_lat", lat2, 27);
    chk("b2b_second_res", res, 32'h3EAAAAAB);

    // Reset asserted at edge 10 of an operation aborts it.
    s_if.start = 1'b1; s_if.dividend = 32'h40C00000; s_if.divisor = 32'h40000000;
    @(posedge clk); #1;
    s_if.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_busy",   s_if.busy,   0);
    chk("abort_valid",  s_if.valid,  0);
    chk("abort_result", s_if.result, 0);
    chk("abort_flags",  s_if.flags,  0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    nval = 0;
    repeat (40) begin @(posedge clk); #1; if (s_if.valid) nval++; end
    chk("abort_no_valid", nval, 0);

    // Random operands against the model, both formats.
    for (int i = 0; i < 60; i++) begin
      bit hp;
      int ew, mw, mode;
      hp = (i % 3 == 0);
      ew = hp ? 5 : 8;
      mw = hp ? 10 : 23;
      ra = $urandom; rb = $urandom;
      if (hp) begin ra = ra & 32'hFFFF; rb = rb & 32'hFFFF; end
      mode = $urandom_range(0, 9);
      if (mode == 0) ra = ra & ~(((32'd1 << ew) - 1) << mw);
      if (mode == 1) rb = rb | (((32'd1 << ew) - 1) << mw);
      if (mode == 2) rb = rb & ~(((32'd1 << ew) - 1) << mw);
      ref_div(longint'(ra), longint'(rb), ew, mw, eres, efl, espec);
      run(hp, ra, rb, res, fl, lat, b0, bend);
      chk($sformatf("rnd%0d_res(%0h/%0h)", i, ra, rb), res, eres);
      chk($sformatf("rnd%0d_flags", i), fl, efl);
      chk($sformatf("rnd%0d_lat", i), lat, espec ? 1 : mw + 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
